// File: rtl/pcu_pkg.sv
// rtl/pcu_pkg.sv - shared state, opcode and enable encodings for param_control_unit
package pcu_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR,
        S_IMM, S_JTGT, S_ALU, S_HALT, S_TRAP
    } state_t;

    localparam logic [31:0] OP_NOP      = 32'd0;
    localparam logic [31:0] OP_LOADAC   = 32'd1;
    localparam logic [31:0] OP_STAC     = 32'd2;
    localparam logic [31:0] OP_MOVACR   = 32'd3;
    localparam logic [31:0] OP_MOVRAC   = 32'd4;
    localparam logic [31:0] OP_ADD      = 32'd5;
    localparam logic [31:0] OP_SUB      = 32'd6;
    localparam logic [31:0] OP_LSH      = 32'd7;
    localparam logic [31:0] OP_RSH      = 32'd8;
    localparam logic [31:0] OP_INC      = 32'd9;
    localparam logic [31:0] OP_LOADIM   = 32'd10;
    localparam logic [31:0] OP_JUMP     = 32'd11;
    localparam logic [31:0] OP_JUMPZ    = 32'd12;
    localparam logic [31:0] OP_JUMPNZ   = 32'd13;
    localparam logic [31:0] OP_MOVACDAR = 32'd14;
    localparam logic [31:0] OP_MOVDARAC = 32'd15;
    localparam logic [31:0] OP_END      = 32'd63;

    localparam int RS_NONE = 0;
    localparam int RS_IMEM = 1;
    localparam int RS_DMEM = 2;
    localparam int RS_AC   = 3;
    localparam int RS_DAR  = 4;
    localparam int RS_REG0 = 5;

    localparam int WE_PC    = 0;
    localparam int WE_IR    = 1;
    localparam int WE_DAR   = 2;
    localparam int WE_AC    = 3;
    localparam int WE_ACALU = 4;
    localparam int WE_REG0  = 5;

    localparam int INC_PC   = 0;
    localparam int INC_AC   = 1;
    localparam int INC_DAR  = 2;
    localparam int INC_REG0 = 3;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_LSH  = 3'd3;
    localparam logic [2:0] ALU_RSH  = 3'd4;

    // INC reuses two index values to reach AC and DAR
    localparam logic [3:0] IDX_AC  = 4'd15;
    localparam logic [3:0] IDX_DAR = 4'd14;

    function automatic int rs_width(input int num_regs);
        return $clog2(5 + num_regs);
    endfunction

endpackage

// File: rtl/pcu_decode.sv
// rtl/pcu_decode.sv - opcode/index legality and EXEC-state enable decode
module pcu_decode
    import pcu_pkg::*;
#(
    parameter int NUM_REGS = 6,
    parameter int OPC_W    = 6,
    parameter int RS_W     = 4,
    parameter int WE_W     = 11,
    parameter int INC_W    = 9
) (
    input  logic [OPC_W-1:0] opc_i,
    input  logic [3:0]       idx_i,
    input  logic             z_flag_i,
    output logic             illegal_o,
    output state_t           next_o,
    output logic             skip_o,
    output logic [RS_W-1:0]  read_sel_o,
    output logic [WE_W-1:0]  write_en_o,
    output logic [INC_W-1:0] inc_en_o,
    output logic [2:0]       alu_op_o
);

    logic [31:0] opc;
    logic        idx_ok;

    assign opc    = 32'(opc_i);
    assign idx_ok = 32'(idx_i) < NUM_REGS;

    always_comb begin
        illegal_o  = 1'b0;
        next_o     = S_FETCH;
        skip_o     = 1'b0;
        read_sel_o = RS_W'(RS_NONE);
        write_en_o = '0;
        inc_en_o   = '0;
        alu_op_o   = ALU_PASS;
        case (opc)
            OP_NOP: inc_en_o[INC_PC] = 1'b1;
            OP_LOADAC: begin
                read_sel_o         = RS_W'(RS_AC);
                write_en_o[WE_DAR] = 1'b1;
                next_o             = S_MEMRD;
            end
            OP_STAC: next_o = S_MEMWR;
            OP_MOVACR: begin
                read_sel_o       = RS_W'(RS_AC);
                inc_en_o[INC_PC] = 1'b1;
                if (idx_ok) write_en_o = WE_W'(1) << (WE_REG0 + 32'(idx_i));
                else        illegal_o  = 1'b1;
            end
            OP_MOVRAC: begin
                inc_en_o[INC_PC] = 1'b1;
                if (idx_ok) begin
                    read_sel_o        = RS_W'(RS_REG0 + 32'(idx_i));
                    write_en_o[WE_AC] = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_ADD: begin alu_op_o = ALU_ADD; next_o = S_ALU; end
            OP_SUB: begin alu_op_o = ALU_SUB; next_o = S_ALU; end
            OP_LSH: begin alu_op_o = ALU_LSH; next_o = S_ALU; end
            OP_RSH: begin alu_op_o = ALU_RSH; next_o = S_ALU; end
            OP_INC: begin
                inc_en_o[INC_PC] = 1'b1;
                if (idx_i == IDX_AC)       inc_en_o[INC_AC]  = 1'b1;
                else if (idx_i == IDX_DAR) inc_en_o[INC_DAR] = 1'b1;
                else if (idx_ok)           inc_en_o = inc_en_o | (INC_W'(1) << (INC_REG0 + 32'(idx_i)));
                else                       illegal_o = 1'b1;
            end
            OP_LOADIM: begin inc_en_o[INC_PC] = 1'b1; next_o = S_IMM; end
            OP_JUMP:   begin inc_en_o[INC_PC] = 1'b1; next_o = S_JTGT; end
            // not-taken branches still visit JTGT, which then only skips the operand
            OP_JUMPZ:  begin inc_en_o[INC_PC] = 1'b1; next_o = S_JTGT; skip_o = !z_flag_i; end
            OP_JUMPNZ: begin inc_en_o[INC_PC] = 1'b1; next_o = S_JTGT; skip_o = z_flag_i; end
            OP_MOVACDAR: begin
                read_sel_o         = RS_W'(RS_AC);
                write_en_o[WE_DAR] = 1'b1;
                inc_en_o[INC_PC]   = 1'b1;
            end
            OP_MOVDARAC: begin
                read_sel_o        = RS_W'(RS_DAR);
                write_en_o[WE_AC] = 1'b1;
                inc_en_o[INC_PC]  = 1'b1;
            end
            OP_END:  next_o = S_HALT;
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) next_o = S_TRAP;
    end

endmodule

// File: rtl/param_control_unit.sv
// rtl/param_control_unit.sv - fetch/decode/execute sequencer with req/ready memory handshake
module param_control_unit
    import pcu_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 6,
    parameter  int OPC_W    = 6,
    localparam int RS_W     = rs_width(NUM_REGS),
    localparam int WE_W     = 5 + NUM_REGS,
    localparam int INC_W    = 3 + NUM_REGS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] instruction_i,
    input  logic              z_flag_i,
    input  logic              mem_ready_i,
    output logic              mem_req_o,
    output logic              mem_sel_o,
    output logic              mem_we_o,
    output logic [RS_W-1:0]   read_sel_o,
    output logic [WE_W-1:0]   write_en_o,
    output logic [INC_W-1:0]  inc_en_o,
    output logic [2:0]        alu_op_o,
    output logic              end_process_o,
    output logic              error_o
);

    state_t state_q, state_d;
    logic   skip_q, skip_d;
    logic   end_q, end_d;
    logic   err_q, err_d;

    logic             dec_illegal;
    state_t           dec_next;
    logic             dec_skip;
    logic [RS_W-1:0]  dec_read_sel;
    logic [WE_W-1:0]  dec_write_en;
    logic [INC_W-1:0] dec_inc_en;
    logic [2:0]       dec_alu_op;

    if (DATA_W > OPC_W + 4) begin : g_spare
        logic unused_hi;
        assign unused_hi = ^instruction_i[DATA_W-1:OPC_W+4];
    end

    pcu_decode #(
        .NUM_REGS(NUM_REGS),
        .OPC_W   (OPC_W),
        .RS_W    (RS_W),
        .WE_W    (WE_W),
        .INC_W   (INC_W)
    ) u_decode (
        .opc_i     (instruction_i[OPC_W-1:0]),
        .idx_i     (instruction_i[OPC_W+3:OPC_W]),
        .z_flag_i  (z_flag_i),
        .illegal_o (dec_illegal),
        .next_o    (dec_next),
        .skip_o    (dec_skip),
        .read_sel_o(dec_read_sel),
        .write_en_o(dec_write_en),
        .inc_en_o  (dec_inc_en),
        .alu_op_o  (dec_alu_op)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            skip_q  <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        mem_req_o  = 1'b0;
        mem_sel_o  = 1'b0;
        mem_we_o   = 1'b0;
        read_sel_o = RS_W'(RS_NONE);
        write_en_o = '0;
        inc_en_o   = '0;
        alu_op_o   = ALU_PASS;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o  = 1'b1;
                read_sel_o = RS_W'(RS_IMEM);
                if (mem_ready_i) begin
                    write_en_o[WE_IR] = 1'b1;
                    state_d           = S_DECODE;
                end
            end
            S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                read_sel_o = dec_read_sel;
                write_en_o = dec_write_en;
                inc_en_o   = dec_inc_en;
                alu_op_o   = dec_alu_op;
                skip_d     = dec_skip;
                state_d    = dec_next;
            end
            S_MEMRD: begin
                mem_req_o  = 1'b1;
                mem_sel_o  = 1'b1;
                read_sel_o = RS_W'(RS_DMEM);
                if (mem_ready_i) begin
                    write_en_o[WE_AC] = 1'b1;
                    inc_en_o[INC_PC]  = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_MEMWR: begin
                mem_req_o  = 1'b1;
                mem_sel_o  = 1'b1;
                mem_we_o   = 1'b1;
                read_sel_o = RS_W'(RS_AC);
                if (mem_ready_i) begin
                    inc_en_o[INC_PC] = 1'b1;
                    state_d          = S_FETCH;
                end
            end
            S_IMM: begin
                mem_req_o  = 1'b1;
                read_sel_o = RS_W'(RS_IMEM);
                if (mem_ready_i) begin
                    write_en_o[WE_AC] = 1'b1;
                    inc_en_o[INC_PC]  = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_JTGT: begin
                if (skip_q) begin
                    inc_en_o[INC_PC] = 1'b1;
                    state_d          = S_FETCH;
                end else begin
                    mem_req_o  = 1'b1;
                    read_sel_o = RS_W'(RS_IMEM);
                    if (mem_ready_i) begin
                        write_en_o[WE_PC] = 1'b1;
                        state_d           = S_FETCH;
                    end
                end
            end
            S_ALU: begin
                alu_op_o             = dec_alu_op;
                write_en_o[WE_ACALU] = 1'b1;
                inc_en_o[INC_PC]     = 1'b1;
                state_d              = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        end_d = (state_d == S_HALT);
        err_d = (state_d == S_TRAP);
    end

    assign end_process_o = end_q;
    assign error_o       = err_q;

endmodule

// File: tb/tb_param_control_unit.sv
// tb/tb_param_control_unit.sv - directed self-checking bench for param_control_unit
module tb_param_control_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] instruction_i = 16'h0000;
    logic        z_flag_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        mem_req_o, mem_sel_o, mem_we_o;
    logic [3:0]  read_sel_o;
    logic [10:0] write_en_o;
    logic [8:0]  inc_en_o;
    logic [2:0]  alu_op_o;
    logic        end_process_o, error_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    param_control_unit #(.DATA_W(16), .NUM_REGS(6), .OPC_W(6)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .instruction_i(instruction_i),
        .z_flag_i     (z_flag_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_sel_o    (mem_sel_o),
        .mem_we_o     (mem_we_o),
        .read_sel_o   (read_sel_o),
        .write_en_o   (write_en_o),
        .inc_en_o     (inc_en_o),
        .alu_op_o     (alu_op_o),
        .end_process_o(end_process_o),
        .error_o      (error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic co(input string tag, input logic req, input logic sel, input logic mwe,
                      input logic [3:0] rs, input logic [10:0] we, input logic [8:0] inc,
                      input logic [2:0] alu);
        chk(tag, {2'b0, mem_req_o, mem_sel_o, mem_we_o, read_sel_o, write_en_o, inc_en_o, alu_op_o},
                 {2'b0, req, sel, mwe, rs, we, inc, alu});
    endtask

    task automatic zero(input string tag);
        co(tag, 1'b0, 1'b0, 1'b0, 4'd0, 11'h000, 9'h000, 3'd0);
    endtask

    task automatic flags(input string tag, input logic e, input logic r);
        chk(tag, {30'b0, end_process_o, error_o}, {30'b0, e, r});
    endtask

    task automatic nx(input logic st, input logic rdy, input logic z, input logic [15:0] ins);
        @(posedge clk_i);
        #2;
        start_i = st; mem_ready_i = rdy; z_flag_i = z; instruction_i = ins;
        #2;
    endtask

    task automatic reset_cycle(input string tag);
        rst_ni = 1'b0;
        #1;
        zero(tag);
        flags({tag, "_flags"}, 1'b0, 1'b0);
        nx(1'b0, 1'b0, 1'b0, 16'h0000);
        rst_ni = 1'b1;
    endtask

    task automatic jump_case(input string tag, input logic [15:0] ins, input logic z, input logic taken);
        nx(1'b0, 1'b1, z, ins);  co({tag, "_ir"}, 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(1'b0, 1'b1, z, ins);  zero({tag, "_dec"});
        nx(1'b0, 1'b1, z, ins);  co({tag, "_exec"}, 0, 0, 0, 4'd0, 11'h000, 9'h001, 3'd0);
        nx(1'b0, 1'b1, !z, ins);
        if (taken) co({tag, "_tgt"}, 1, 0, 0, 4'd1, 11'h001, 9'h000, 3'd0);
        else       co({tag, "_skip"}, 0, 0, 0, 4'd0, 11'h000, 9'h001, 3'd0);
    endtask

    initial begin
        // T1: reset, then async reset during a pending fetch
        nx(0, 0, 0, 16'h0000); zero("rst_hold"); flags("rst_flags", 0, 0);
        rst_ni = 1'b1;
        nx(1, 0, 0, 16'h0000); zero("idle_start");
        nx(0, 0, 0, 16'h0000); co("t1_fetch", 1, 0, 0, 4'd1, 11'h000, 9'h000, 3'd0);
        reset_cycle("t1_async");
        nx(0, 1, 0, 16'h0000); zero("t1_idle_a");
        nx(0, 1, 0, 16'h0000); zero("t1_idle_b");

        // T2: NOP with memory always ready
        nx(1, 1, 0, 16'h0000); zero("nop_idle");
        nx(0, 1, 0, 16'h0000); co("nop_c1_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h0000); zero("nop_c2_dec");
        nx(0, 1, 0, 16'h0000); co("nop_c3_inc", 0, 0, 0, 4'd0, 11'h000, 9'h001, 3'd0);
        nx(0, 0, 0, 16'h0001); co("nop_c4_fetch", 1, 0, 0, 4'd1, 11'h000, 9'h000, 3'd0);

        // T3: LOADAC with three wait cycles
        nx(0, 1, 0, 16'h0001); co("ldac_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h0001); zero("ldac_dec");
        nx(0, 1, 0, 16'h0001); co("ldac_exec", 0, 0, 0, 4'd3, 11'h004, 9'h000, 3'd0);
        for (int i = 0; i < 3; i++) begin
            nx(0, 0, 0, 16'h0001); co("ldac_wait", 1, 1, 0, 4'd2, 11'h000, 9'h000, 3'd0);
        end
        nx(0, 1, 0, 16'h0001); co("ldac_ready", 1, 1, 0, 4'd2, 11'h008, 9'h001, 3'd0);
        nx(0, 0, 0, 16'h000C); co("ldac_once", 1, 0, 0, 4'd1, 11'h000, 9'h000, 3'd0);

        // T4: conditional jumps, both polarities
        jump_case("jz_taken", 16'h000C, 1'b1, 1'b1);
        jump_case("jz_not", 16'h000C, 1'b0, 1'b0);
        jump_case("jnz_taken", 16'h000D, 1'b0, 1'b1);
        jump_case("jnz_not", 16'h000D, 1'b1, 1'b0);

        // T5: indexed register move, out-of-range index and illegal opcode
        nx(0, 1, 0, 16'h0143); co("mov5_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h0143); zero("mov5_dec");
        nx(0, 1, 0, 16'h0143); co("mov5_exec", 0, 0, 0, 4'd3, 11'h400, 9'h001, 3'd0);
        nx(0, 1, 0, 16'h0183); co("mov6_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h0183); zero("mov6_dec");
        nx(0, 1, 0, 16'h0183); zero("mov6_trap"); flags("mov6_err", 0, 1);
        nx(1, 1, 0, 16'h0183); zero("mov6_trap_held"); flags("mov6_err_held", 0, 1);
        reset_cycle("trap_rst");
        nx(1, 1, 0, 16'h003E); zero("ill_idle");
        nx(0, 1, 0, 16'h003E); co("ill_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h003E); zero("ill_dec"); flags("ill_dec_flags", 0, 0);
        nx(0, 1, 0, 16'h003E); zero("ill_trap"); flags("ill_err", 0, 1);
        reset_cycle("ill_rst");

        // T6: ADD followed by END
        nx(1, 1, 0, 16'h0005); zero("add_idle");
        nx(0, 1, 0, 16'h0005); co("add_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h0005); zero("add_dec");
        nx(0, 1, 0, 16'h0005); co("add_exec", 0, 0, 0, 4'd0, 11'h000, 9'h000, 3'd1);
        nx(0, 1, 0, 16'h0005); co("add_alu", 0, 0, 0, 4'd0, 11'h010, 9'h001, 3'd1);
        nx(0, 1, 0, 16'h003F); co("end_ir", 1, 0, 0, 4'd1, 11'h002, 9'h000, 3'd0);
        nx(0, 1, 0, 16'h003F); zero("end_dec");
        nx(0, 1, 0, 16'h003F); zero("end_exec"); flags("end_exec_flags", 0, 0);
        nx(0, 1, 0, 16'h003F); zero("halt_out"); flags("halt_flag", 1, 0);
        for (int i = 0; i < 3; i++) begin
            nx(1, 1, 1, 16'h0000); zero("halt_held_out"); flags("halt_held", 1, 0);
        end
        reset_cycle("halt_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
